// File: rtl/asym_tile_pkg.sv
// Shared definitions for the asymmetric tile buffer sequencer.
// Holds the FSM state encodings and the tile-geometry helpers.
package asym_tile_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int calc_max_rows(input int depth, input int ratio);
        return depth / ratio;
    endfunction

    function automatic int calc_row_w(input int depth, input int ratio);
        return $clog2((depth / ratio) + 1);
    endfunction

endpackage

// File: rtl/asym_tile_ofifo.sv
// Two-entry wide-row output FIFO for the drain path.
// Ports: i_push/i_data write, i_pop read, o_head = oldest entry, o_count = fill level.
module asym_tile_ofifo #(
    parameter int WIDTH = 257
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/asym_tile_ctrl.sv
// Narrow-write / wide-read tile buffer sequencer: fills a tile row-major, then drains wide rows.
// Ports: start/cfg_rows control, s_* narrow input stream, mem_if_* RAM port, m_* wide output stream, busy/done status.
module asym_tile_ctrl
    import asym_tile_pkg::*;
#(
    parameter  int DATA_RATIO = 8,
    parameter  int ADDR_DEPTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int MAX_ROWS   = calc_max_rows(ADDR_DEPTH, DATA_RATIO),
    localparam int ROW_W      = calc_row_w(ADDR_DEPTH, DATA_RATIO),
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int WIDE_W     = DATA_RATIO * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      cfg_rows,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [STRB_W-1:0]     s_strb,
    output logic                  mem_if_write,
    output logic [ADDR_WIDTH-1:0] mem_if_address,
    output logic [DATA_WIDTH-1:0] mem_if_write_data,
    output logic [STRB_W-1:0]     mem_if_write_strb,
    input  logic [WIDE_W-1:0]     mem_if_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDE_W-1:0]     m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int COL_W = $clog2(DATA_RATIO);

    state_t           r_state;
    logic [ROW_W-1:0] r_rows;
    logic [ROW_W-1:0] r_wr_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_rd_row;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             r_done;

    logic [ROW_W-1:0] w_cfg_rows;
    logic             w_wr;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_pop;
    logic             w_issue;
    logic [2:0]       w_occ;
    logic [1:0]       w_count;
    logic [WIDE_W:0]  w_head;
    logic             w_head_last;
    logic             w_tile_end;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_cfg_rows = (cfg_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : cfg_rows;

    assign w_wr      = (r_state == ST_FILL) && s_valid;
    assign w_col_end = (r_col == COL_W'(DATA_RATIO - 1));
    assign w_row_end = (r_wr_row == (r_rows - ROW_W'(1)));

    // Occupancy counts rows already buffered plus the one still in the RAM
    // pipeline; a slot freed by this cycle's pop may be reused immediately.
    assign w_pop   = m_valid && m_ready;
    assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue = (r_state == ST_DRAIN) && (r_rd_row < r_rows) && (w_occ < 3'd2);

    assign w_head_last = w_head[WIDE_W];
    assign w_tile_end  = w_pop && w_head_last;

    always_comb begin
        w_addr = '0;
        if (r_state == ST_FILL) begin
            w_addr = ADDR_WIDTH'(r_wr_row) * ADDR_WIDTH'(DATA_RATIO)
                   + ADDR_WIDTH'(r_col);
        end else if (w_issue) begin
            w_addr = ADDR_WIDTH'(r_rd_row) * ADDR_WIDTH'(DATA_RATIO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rows   <= '0;
            r_wr_row <= '0;
            r_col    <= '0;
            r_rd_row <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_wr_row <= '0;
                    r_col    <= '0;
                    r_rd_row <= '0;
                    if (start) begin
                        if (w_cfg_rows == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rows  <= w_cfg_rows;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_wr) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            if (w_row_end) begin
                                r_wr_row <= '0;
                                r_state  <= ST_DRAIN;
                            end else begin
                                r_wr_row <= r_wr_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_issue) begin
                        r_rd_row <= r_rd_row + ROW_W'(1);
                    end
                    if (w_tile_end) begin
                        r_rd_row <= '0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM read data lands one cycle after the address; tag it with its last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_row == (r_rows - ROW_W'(1)));
        end
    end

    asym_tile_ofifo #(
        .WIDTH (WIDE_W + 1)
    ) u_ofifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, mem_if_read_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign s_ready           = (r_state == ST_FILL);
    assign mem_if_write      = w_wr;
    assign mem_if_address    = w_addr;
    assign mem_if_write_data = s_data;
    assign mem_if_write_strb = s_strb;
    assign m_valid           = (w_count != 2'd0);
    assign m_data            = w_head[WIDE_W-1:0];
    assign m_last            = m_valid && w_head_last;
    assign busy              = (r_state != ST_IDLE);
    assign done              = r_done;

endmodule

// File: tb/tb_asym_tile_ctrl.sv
// Scoreboard bench for asym_tile_ctrl with a behavioural wide-read RAM.
// Writes and rows are queued when driven and compared when the DUT emits them.
module tb_asym_tile_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   cfg_rows;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [3:0]   s_strb;
    logic         mem_if_write;
    logic [31:0]  mem_if_address;
    logic [31:0]  mem_if_write_data;
    logic [3:0]   mem_if_write_strb;
    logic [255:0] mem_if_read_data;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;

    asym_tile_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .cfg_rows          (cfg_rows),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_strb            (s_strb),
        .mem_if_write      (mem_if_write),
        .mem_if_address    (mem_if_address),
        .mem_if_write_data (mem_if_write_data),
        .mem_if_write_strb (mem_if_write_strb),
        .mem_if_read_data  (mem_if_read_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
        .busy              (busy),
        .done              (done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic         last;
        logic [255:0] data;
    } row_t;

    wr_t         q_wr[$];
    row_t        q_rows[$];
    logic [31:0] model [32];
    logic [31:0] ram   [32];

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;
    int max_streak = 0;
    int cur_streak = 0;
    int n_popped   = 0;
    logic [31:0] max_rd = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural asymmetric RAM: byte-strobed narrow writes, registered wide reads.
    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_if_write && mem_if_address < 32) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_if_write_strb[b])
                    ram[mem_if_address[4:0]][8*b +: 8] <= mem_if_write_data[8*b +: 8];
            end
        end
        for (int c = 0; c < 8; c++) begin
            mem_if_read_data[32*c +: 32] <= ram[{mem_if_address[4:3], 3'(c)}];
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        logic         done_pend;
        logic         stall_prev;
        logic [255:0] prev_data;
        logic         prev_last;
        wr_t          w;
        row_t         r;
        done_pend  = 1'b0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_pend  = 1'b0;
                stall_prev = 1'b0;
                cur_streak = 0;
            end else begin
                if (mem_if_write) begin
                    if (q_wr.size() == 0) begin
                        chk("wr_unexpected", 1, 0);
                    end else begin
                        w = q_wr.pop_front();
                        chk("wr_addr", mem_if_address, w.addr);
                        chk("wr_data", mem_if_write_data, w.data);
                        chk("wr_strb", mem_if_write_strb, w.strb);
                        chk("wr_svalid", s_valid, 1);
                    end
                end
                if (busy && !s_ready && mem_if_address > max_rd)
                    max_rd = mem_if_address;
                if (stall_prev) begin
                    chk("hold_data", m_data, prev_data);
                    chk("hold_last", m_last, prev_last);
                end
                if (done_pend || done) chk("done", done, done_pend);
                if (done_pend) chk("busy_at_done", busy, 0);
                done_pend = 1'b0;
                if (!busy && start && cfg_rows == 3'd0) done_pend = 1'b1;
                if (m_valid && m_ready) begin
                    cur_streak++;
                    if (cur_streak > max_streak) max_streak = cur_streak;
                    n_popped++;
                    if (q_rows.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        r = q_rows.pop_front();
                        chk("rd_data", m_data, r.data);
                        chk("rd_last", m_last, r.last);
                        if (r.last) done_pend = 1'b1;
                    end
                end else begin
                    cur_streak = 0;
                end
                stall_prev = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_tile(input logic [2:0] cfg);
        start    = 1'b1;
        cfg_rows = cfg;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic run_fill(input int nwords, input int base, input bit randv, input bit halfstrb);
        wr_t w;
        for (int i = 0; i < nwords; i++) begin
            if (randv) begin
                s_valid = 1'b0;
                tick($urandom_range(0, 2));
            end
            s_valid = 1'b1;
            s_data  = 32'(base + i);
            s_strb  = (halfstrb && (i % 2 == 1)) ? 4'b0101 : 4'b1111;
            for (int b = 0; b < 4; b++) begin
                if (s_strb[b]) model[i][8*b +: 8] = s_data[8*b +: 8];
            end
            w.addr = 32'(i);
            w.data = s_data;
            w.strb = s_strb;
            q_wr.push_back(w);
            tick(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic push_rows(input int rows);
        row_t r;
        for (int k = 0; k < rows; k++) begin
            for (int c = 0; c < 8; c++) r.data[32*c +: 32] = model[k*8 + c];
            r.last = (k == rows - 1);
            q_rows.push_back(r);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy || q_rows.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_timeout", (n < budget), 1);
        tick(2);
    endtask

    task automatic new_tile();
        max_streak = 0;
        n_popped   = 0;
        max_rd     = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_rows = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_strb   = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        chk("rst_s_ready", s_ready, 0);
        chk("rst_write", mem_if_write, 0);
        chk("rst_addr", mem_if_address, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Two-row tile, consumer always ready.
        new_tile();
        ready_mode = 0;
        start_tile(3'd2);
        run_fill(16, 0, 1'b0, 1'b0);
        push_rows(2);
        wait_drain(200);
        chk("t1_streak", max_streak, 2);
        chk("t1_max_rd", max_rd, 8);
        chk("t1_rows", n_popped, 2);

        // Stalled consumer plus a start pulse during drain.
        new_tile();
        ready_mode = 2;
        start_tile(3'd2);
        run_fill(16, 'h100, 1'b0, 1'b0);
        push_rows(2);
        tick(2);
        start_tile(3'd1);
        tick(2);
        chk("t2_busy_stall", busy, 1);
        ready_mode = 0;
        wait_drain(200);
        chk("t2_rows", n_popped, 2);
        chk("t2_start_ignored", busy, 0);

        // Gappy input with partial strobes, random backpressure.
        new_tile();
        ready_mode = 1;
        start_tile(3'd2);
        run_fill(16, 'h200, 1'b1, 1'b1);
        push_rows(2);
        wait_drain(400);
        chk("t3_rows", n_popped, 2);
        ready_mode = 0;

        // Empty tile.
        start_tile(3'd0);
        chk("t4_busy", busy, 0);
        tick(3);
        chk("t4_busy_after", busy, 0);

        // Asynchronous reset mid-fill.
        start_tile(3'd2);
        run_fill(5, 'h300, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_s_ready", s_ready, 0);
        chk("ar_write", mem_if_write, 0);
        chk("ar_addr", mem_if_address, 0);
        chk("ar_m_valid", m_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        q_wr.delete();
        new_tile();
        start_tile(3'd1);
        run_fill(8, 'h400, 1'b0, 1'b0);
        push_rows(1);
        wait_drain(200);
        chk("t5_rows", n_popped, 1);

        // Full-depth tile.
        new_tile();
        start_tile(3'd4);
        run_fill(32, 'h500, 1'b0, 1'b0);
        push_rows(4);
        wait_drain(200);
        chk("t6_max_rd", max_rd, 24);
        chk("t6_streak", max_streak, 4);
        chk("t6_rows", n_popped, 4);

        // Oversized request clamps to the RAM depth.
        new_tile();
        start_tile(3'd7);
        run_fill(32, 'h600, 1'b0, 1'b0);
        push_rows(4);
        wait_drain(200);
        chk("t7_max_rd", max_rd, 24);
        chk("t7_rows", n_popped, 4);

        chk("wr_q_empty", q_wr.size(), 0);
        chk("rd_q_empty", q_rows.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
